// File: rtl/traffic_light_monitor.sv
// Traffic light sequence monitor: samples both lamp groups, tracks the six-phase cycle and latches the first fault.
// Define TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN to add the min/max dwell checks (fault codes 4 and 5).
module traffic_light_monitor #(
    parameter logic [7:0] GREEN_CYC  = 8'd6,
    parameter logic [7:0] YELLOW_CYC = 8'd2,
    parameter logic [7:0] ALLRED_CYC = 8'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] lightA,
    input  logic [2:0] lightB,
    input  logic       clear,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       locked,
    output logic [2:0] phase,
    output logic [7:0] cycles_done
);
    localparam logic [2:0] LAMP_G  = 3'b001;
    localparam logic [2:0] LAMP_Y  = 3'b010;
    localparam logic [2:0] LAMP_R  = 3'b100;
    localparam logic [2:0] PH_NONE = 3'd7;

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t     state_q, state_d;
    logic [2:0] a_q, a_d, b_q, b_d;
    logic [2:0] phase_q, phase_d;
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] cycles_q, cycles_d;
    logic       fault_q, fault_d;
    logic [2:0] code_q, code_d;

    logic [2:0] obs, nxt, code_now;
    logic [7:0] dwell_inc;
    logic       hold, adv;
    logic       err1, err2, err3, err4, err5;

`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
    logic       first_q, first_d;
    logic [7:0] limit;
`endif

    if (GREEN_CYC == 8'd0 || YELLOW_CYC == 8'd0 || ALLRED_CYC == 8'd0) begin : g_bad_dwell_param
        $error("traffic_light_monitor: dwell parameters must lie in 1..255");
    end

    // Decode the sampled lamps and classify faults for this cycle.
    always_comb begin
        a_d = lightA;
        b_d = lightB;
        obs = PH_NONE;
        if (a_q == LAMP_G && b_q == LAMP_R)      obs = 3'd0;
        else if (a_q == LAMP_Y && b_q == LAMP_R) obs = 3'd1;
        else if (a_q == LAMP_R && b_q == LAMP_G) obs = 3'd3;
        else if (a_q == LAMP_R && b_q == LAMP_Y) obs = 3'd4;
        else if (a_q == LAMP_R && b_q == LAMP_R) begin
            // All-red is only meaningful relative to the phase it follows.
            if (phase_q == 3'd1 || phase_q == 3'd2)      obs = 3'd2;
            else if (phase_q == 3'd4 || phase_q == 3'd5) obs = 3'd5;
        end

        nxt       = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
        hold      = (state_q == LOCKED) && (obs == phase_q);
        adv       = (state_q == LOCKED) && (obs == nxt);
        dwell_inc = (dwell_q == 8'hff) ? 8'hff : dwell_q + 8'd1;

        err1 = !$onehot(a_q) || !$onehot(b_q);
        err2 = (a_q != LAMP_R) && (b_q != LAMP_R);
        err3 = (state_q == LOCKED) && !hold && !adv;
        err4 = 1'b0;
        err5 = 1'b0;
`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
        case (phase_q)
            3'd0, 3'd3: limit = GREEN_CYC;
            3'd1, 3'd4: limit = YELLOW_CYC;
            default:    limit = ALLRED_CYC;
        endcase
        err4 = adv && !first_q && (dwell_q < limit);
        err5 = hold && !first_q && ({1'b0, dwell_inc} == {1'b0, limit} + 9'd1);
`endif

        code_now = 3'd0;
        if (err1)      code_now = 3'd1;
        else if (err2) code_now = 3'd2;
        else if (err3) code_now = 3'd3;
        else if (err4) code_now = 3'd4;
        else if (err5) code_now = 3'd5;
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        dwell_d  = dwell_q;
        cycles_d = cycles_q;
`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
        first_d  = first_q;
`endif
        case (state_q)
            UNLOCKED: begin
                if (obs == 3'd0 || obs == 3'd3) begin
                    state_d = LOCKED;
                    phase_d = obs;
                    dwell_d = 8'd1;
`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
                    first_d = 1'b1;
`endif
                end
            end
            LOCKED: begin
                if (hold) begin
                    dwell_d = dwell_inc;
                end else if (adv) begin
                    phase_d = obs;
                    dwell_d = 8'd1;
`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
                    first_d = 1'b0;
`endif
                    if (phase_q == 3'd5 && cycles_q != 8'hff)
                        cycles_d = cycles_q + 8'd1;
                end
            end
            default: state_d = UNLOCKED;
        endcase

        if (code_now != 3'd0) begin
            state_d  = UNLOCKED;
            phase_d  = PH_NONE;
            dwell_d  = 8'd0;
            cycles_d = cycles_q;
        end

        // A clear makes room for a fault detected in the same cycle.
        if (clear) begin
            fault_d = (code_now != 3'd0);
            code_d  = code_now;
        end else begin
            fault_d = fault_q || (code_now != 3'd0);
            code_d  = (code_q == 3'd0) ? code_now : code_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= LAMP_R;
            b_q      <= LAMP_R;
            state_q  <= UNLOCKED;
            phase_q  <= PH_NONE;
            dwell_q  <= 8'd0;
            cycles_q <= 8'd0;
            fault_q  <= 1'b0;
            code_q   <= 3'd0;
`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
            first_q  <= 1'b0;
`endif
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            state_q  <= state_d;
            phase_q  <= phase_d;
            dwell_q  <= dwell_d;
            cycles_q <= cycles_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
            first_q  <= first_d;
`endif
        end
    end

    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign locked      = (state_q == LOCKED);
    assign phase       = phase_q;
    assign cycles_done = cycles_q;
endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 GREEN_CYC, 6, required green dwell in clk cycles (1..255).
REQ-002 YELLOW_CYC, 2, required yellow dwell in clk cycles (1..255).
REQ-003 ALLRED_CYC, 2, required all-red dwell in clk cycles (1..255).
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 lightA  input  3  country lamps, one-hot: 001 green, 010 yellow, 100 red.
REQ-007 lightB  input  3  highway lamps, same encoding.
REQ-008 clear  input  1  synchronous clear of the sticky fault.
REQ-009 fault  output  1  sticky fault flag.
REQ-010 fault_code  output  3  code of the first fault since the last clear or reset.
REQ-011 locked  output  1  monitor tracking the sequence.
REQ-012 phase  output  3  tracked phase 0..5; 7 when unlocked.
REQ-013 cycles_done  output  8  count of completed sequences, saturating.

Function
REQ-014 The block SHALL register lightA/lightB at every edge; all checks SHALL use the registered value, and all outputs SHALL be registered, so a response appears at the second rising edge after the lamp value is applied.
REQ-015 Decode: P0=(A green,B red), P1=(A yellow,B red), P3=(A red,B green), P4=(A red,B yellow); all-red SHALL decode as P2 after P1 or P2, and as P5 after P4 or P5.
REQ-016 Fault codes: 1 = a lamp group is not one-hot; 2 = both groups are non-red; 3 = illegal transition; 4 = dwell too short; 5 = dwell too long.
REQ-017 When several faults occur in one cycle, the lowest code SHALL be recorded.
REQ-018 Codes 1 and 2 SHALL be checked in every state; codes 3 to 5 SHALL be checked only while locked.
REQ-019 FSM UNLOCKED: on a registered P0 or P3, go to LOCKED with phase set to it and dwell=1; all other values SHALL leave the FSM in UNLOCKED.
REQ-020 The only legal LOCKED moves SHALL be: hold the current phase, P0->P1, P1->P2, P2->P3, P3->P4, P4->P5, P5->P0.
REQ-021 Any other move SHALL raise code 3.
REQ-022 dwell SHALL be an 8-bit count of consecutive cycles in the current phase, saturating at 255, reloaded to 1 on each phase change.
REQ-023 On any fault the FSM SHALL return to UNLOCKED, with phase=7 and locked=0.
REQ-024 fault SHALL stay set, and fault_code SHALL hold the first code, until clear or reset.
REQ-025 A later fault SHALL NOT overwrite a nonzero fault_code.
REQ-026 clear SHALL zero fault and fault_code at the next edge; if a new fault occurs in the same cycle, the new fault SHALL be recorded instead.
REQ-027 cycles_done SHALL increment on each locked P5->P0 move and saturate at 255; clear SHALL NOT affect it.

Reset
REQ-028 Reset SHALL immediately set: fault=0, fault_code=0, locked=0, phase=7, cycles_done=0, dwell=0, FSM=UNLOCKED.
REQ-029 Reset SHALL immediately set both lamp sample registers to 100 (red).
REQ-030 Reset asserted mid-sequence SHALL discard all tracking, and relock SHALL then follow REQ-019.

Configuration
REQ-031 With TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN defined, leaving a phase with dwell less than its parameter SHALL raise code 4.
REQ-032 With the macro defined, reaching dwell equal to its parameter plus 1 SHALL raise code 5.
REQ-033 The phase parameters are: GREEN_CYC for P0/P3, YELLOW_CYC for P1/P4, ALLRED_CYC for P2/P5.
REQ-034 The dwell checks SHALL be skipped for the first phase after locking.
REQ-035 Without the macro, codes 4 and 5 SHALL never be raised, and no dwell comparison logic SHALL be present; the dwell counter itself SHALL remain.

Verification
REQ-036 Reset, then nominal 6/2/2/6/2/2-cycle sequence for 2 full loops plus a return to P0 -> locked=1, fault=0, cycles_done=2, phase tracks 0..5.
REQ-037 lightA=011 held 1 cycle -> fault=1, fault_code=1, locked=0, phase=7 at the second edge.
REQ-038 lightA=001 with lightB=001 -> fault_code=2; lightA=011 with lightB=001 -> fault_code=1 (priority).
REQ-039 Locked in P0, drive P3 directly -> fault_code=3; then a clear pulse -> fault=0, fault_code=0, and the monitor relocks on P3.
REQ-040 Macro defined: yellow held 1 cycle -> code 4; green held 7 cycles -> code 5 on the 7th sampled cycle. Macro undefined: same stimulus -> fault=0.
REQ-041 Reset pulse mid-P3 with fault=1 and cycles_done=3 -> all outputs return to reset values immediately.
